branch_predictor_gshare: RTL and testbench

- Dynamic conditional-branch predictor that supplies the fetch stage's taken/not-taken prediction each cycle. It sits directly upstream of the fetch stage.
- Holds a table of 2-bit saturating counters indexed by the gshare hash of PC and a speculative global history register (GHR).
- Trains from branch resolution in the execute stage and repairs the GHR on misprediction.
- Also keeps saturating prediction and misprediction counters for performance debug.

---
 rtl/branch_predictor_gshare.sv | 114 +++++++++++
 tb/tb_branch_predictor_gshare.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// Gshare conditional-branch predictor: 2-bit counter table indexed by PC XOR global history,
// speculative GHR with repair on mispredict, and saturating performance counters.
module branch_predictor_gshare #(
   parameter int INDEX_BITS   = 6,
   parameter int HISTORY_BITS = 4,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             query_pc,
   input  logic                    query_is_cond,
   input  logic                    query_fire,
   output logic                    predict_taken,
   output logic [HISTORY_BITS-1:0] predict_ghr,
   input  logic                    upd_valid,
   input  logic [31:0]             upd_pc,
   input  logic [HISTORY_BITS-1:0] upd_ghr,
   input  logic                    upd_taken,
   input  logic                    upd_mispredict,
   output logic [CNT_WIDTH-1:0]    stat_predictions,
   output logic [CNT_WIDTH-1:0]    stat_mispredicts
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   function automatic logic [INDEX_BITS-1:0] gshare_idx(input logic [INDEX_BITS-1:0] pc_bits,
                                                        input logic [HISTORY_BITS-1:0] hist);
      gshare_idx = pc_bits ^ INDEX_BITS'(hist);
   endfunction

   function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         sat_ctr = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         sat_ctr = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
      sat_inc = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
   endfunction

   logic [1:0]              ctr_q [ENTRIES];
   logic [1:0]              ctr_d;
   logic [HISTORY_BITS-1:0] ghr_q, ghr_d;
   logic [CNT_WIDTH-1:0]    pred_cnt_q, pred_cnt_d;
   logic [CNT_WIDTH-1:0]    misp_cnt_q, misp_cnt_d;
   logic [INDEX_BITS-1:0]   pred_idx_s, upd_idx_s;
   logic                    pred_fire_s, repair_s;
   logic                    unused_pc_bits_s;

   assign unused_pc_bits_s = ^{query_pc[31:INDEX_BITS+2], query_pc[1:0],
                               upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

   assign pred_idx_s    = gshare_idx(query_pc[INDEX_BITS+1:2], ghr_q);
   assign upd_idx_s     = gshare_idx(upd_pc[INDEX_BITS+1:2], upd_ghr);
   assign predict_taken = ctr_q[pred_idx_s][1];
   assign predict_ghr   = ghr_q;
   assign pred_fire_s   = query_fire && query_is_cond;
   assign repair_s      = upd_valid && upd_mispredict;

   assign stat_predictions = pred_cnt_q;
   assign stat_mispredicts = misp_cnt_q;

   // Next-state for the trained entry, history and stats; repair wins over speculative shift.
   always_comb begin
      ctr_d      = sat_ctr(ctr_q[upd_idx_s], upd_taken);
      ghr_d      = ghr_q;
      pred_cnt_d = pred_cnt_q;
      misp_cnt_d = misp_cnt_q;
      if (repair_s) begin
         ghr_d = {upd_ghr[HISTORY_BITS-2:0], upd_taken};
      end else if (pred_fire_s) begin
         ghr_d = {ghr_q[HISTORY_BITS-2:0], predict_taken};
      end else begin
         ghr_d = ghr_q;
      end
      if (pred_fire_s) begin
         pred_cnt_d = sat_inc(pred_cnt_q);
      end else begin
         pred_cnt_d = pred_cnt_q;
      end
      if (repair_s) begin
         misp_cnt_d = sat_inc(misp_cnt_q);
      end else begin
         misp_cnt_d = misp_cnt_q;
      end
   end

   // Counter table: every entry starts weakly not-taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         ctr_q[upd_idx_s] <= ctr_d;
      end
   end

   // History and performance counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr_q      <= '0;
         pred_cnt_q <= '0;
         misp_cnt_q <= '0;
      end else begin
         ghr_q      <= ghr_d;
         pred_cnt_q <= pred_cnt_d;
         misp_cnt_q <= misp_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed self-checking bench for branch_predictor_gshare (4-bit stat counters to reach saturation).
module tb_branch_predictor_gshare;

   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic [31:0]   query_pc;
   logic          query_is_cond;
   logic          query_fire;
   logic          predict_taken;
   logic [3:0]    predict_ghr;
   logic          upd_valid;
   logic [31:0]   upd_pc;
   logic [3:0]    upd_ghr;
   logic          upd_taken;
   logic          upd_mispredict;
   logic [CW-1:0] stat_predictions;
   logic [CW-1:0] stat_mispredicts;

   int checks = 0;
   int errors = 0;

   branch_predictor_gshare #(.INDEX_BITS(6), .HISTORY_BITS(4), .CNT_WIDTH(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .query_pc         (query_pc),
      .query_is_cond    (query_is_cond),
      .query_fire       (query_fire),
      .predict_taken    (predict_taken),
      .predict_ghr      (predict_ghr),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_ghr          (upd_ghr),
      .upd_taken        (upd_taken),
      .upd_mispredict   (upd_mispredict),
      .stat_predictions (stat_predictions),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [3:0] h, input logic t, input logic m);
      upd_valid = 1'b1; upd_pc = pc; upd_ghr = h; upd_taken = t; upd_mispredict = m;
      tick();
      upd_valid = 1'b0; upd_mispredict = 1'b0;
   endtask

   initial begin
      rst = 1'b0; query_pc = 32'h40; query_is_cond = 1'b1; query_fire = 1'b0;
      upd_valid = 1'b0; upd_pc = 32'h0; upd_ghr = 4'h0; upd_taken = 1'b0; upd_mispredict = 1'b0;
      tick(); tick();
      chk("rst_pred", 32'(predict_taken), 32'd0);
      chk("rst_ghr", 32'(predict_ghr), 32'd0);
      rst = 1'b1;
      tick();
      chk("post_rst_pred", 32'(predict_taken), 32'd0);
      chk("post_rst_ghr", 32'(predict_ghr), 32'd0);
      chk("post_rst_spred", 32'(stat_predictions), 32'd0);
      chk("post_rst_smisp", 32'(stat_mispredicts), 32'd0);

      // Two taken mispredicts train entry 0x10 to 11; repair sets ghr to 0001.
      upd(32'h40, 4'h0, 1'b1, 1'b1);
      chk("upd1_ghr", 32'(predict_ghr), 32'h1);
      chk("upd1_smisp", 32'(stat_mispredicts), 32'd1);
      upd(32'h40, 4'h0, 1'b1, 1'b1);
      chk("upd2_ghr", 32'(predict_ghr), 32'h1);
      upd(32'h40, 4'h8, 1'b0, 1'b1);
      chk("upd3_ghr", 32'(predict_ghr), 32'h0);
      chk("upd3_smisp", 32'(stat_mispredicts), 32'd3);
      query_pc = 32'h40; #1;
      chk("trained_pred", 32'(predict_taken), 32'd1);

      // Three fired conditional branches predicted not-taken (idx 0).
      query_pc = 32'h100; query_fire = 1'b1; query_is_cond = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("nt_pred", 32'(predict_taken), 32'd0);
         tick();
         chk("nt_ghr", 32'(predict_ghr), 32'h0);
      end
      chk("nt_spred", 32'(stat_predictions), 32'd3);

      // Non-conditional fires (would predict 1) must not shift or count.
      query_pc = 32'h40; query_is_cond = 1'b0;
      tick(); tick();
      chk("noncond_ghr", 32'(predict_ghr), 32'h0);
      chk("noncond_spred", 32'(stat_predictions), 32'd3);

      // Speculative shift of a taken prediction.
      query_is_cond = 1'b1; #1;
      chk("spec_pred", 32'(predict_taken), 32'd1);
      tick();
      chk("spec_ghr", 32'(predict_ghr), 32'h1);
      chk("spec_spred", 32'(stat_predictions), 32'd4);

      // Repair overrides a same-cycle speculative shift; both stats step.
      query_pc = 32'h44; #1;
      chk("same_pred", 32'(predict_taken), 32'd1);
      upd(32'h80, 4'h6, 1'b0, 1'b1);
      query_fire = 1'b0;
      chk("same_ghr", 32'(predict_ghr), 32'hC);
      chk("same_spred", 32'(stat_predictions), 32'd5);
      chk("same_smisp", 32'(stat_mispredicts), 32'd4);

      // Counter saturation at 00 on entry 0 (ghr=1100, query 0x30 -> idx 0).
      query_pc = 32'h30;
      for (int i = 0; i < 4; i++) begin
         upd(32'h200, 4'h0, 1'b0, 1'b0);
         chk("dec_pred", 32'(predict_taken), 32'd0);
      end
      upd(32'h200, 4'h0, 1'b1, 1'b0);
      chk("sat00_pred", 32'(predict_taken), 32'd0);
      chk("train_ghr_hold", 32'(predict_ghr), 32'hC);

      // Counter saturation at 11 on entry 0x10 (query 0x70 -> idx 0x10).
      query_pc = 32'h70;
      upd(32'h40, 4'h0, 1'b1, 1'b0);
      upd(32'h40, 4'h0, 1'b0, 1'b0);
      chk("sat11_pred", 32'(predict_taken), 32'd1);
      upd(32'h40, 4'h0, 1'b1, 1'b0);

      // Stat counters saturate at all-ones.
      query_fire = 1'b1; query_is_cond = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      query_fire = 1'b0;
      chk("spred_sat", 32'(stat_predictions), 32'd15);
      for (int i = 0; i < 12; i++) upd(32'h40, 4'h0, 1'b1, 1'b1);
      chk("smisp_sat", 32'(stat_mispredicts), 32'd15);
      chk("spred_hold", 32'(stat_predictions), 32'd15);

      // Async reset mid-stream clears entry 0x10 and ghr before the next edge.
      query_pc = 32'h44; #1;
      chk("pre_rst_pred", 32'(predict_taken), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_pred", 32'(predict_taken), 32'd0);
      chk("async_ghr", 32'(predict_ghr), 32'h0);
      upd_valid = 1'b1; upd_pc = 32'h40; upd_ghr = 4'h0; upd_taken = 1'b1; upd_mispredict = 1'b1;
      tick();
      upd_valid = 1'b0; upd_mispredict = 1'b0;
      chk("async_smisp", 32'(stat_mispredicts), 32'd0);
      chk("async_spred", 32'(stat_predictions), 32'd0);
      rst = 1'b1;
      query_pc = 32'h40;
      tick();
      chk("rel_pred", 32'(predict_taken), 32'd0);
      upd(32'h40, 4'h0, 1'b1, 1'b0);
      chk("rel_ctr01", 32'(predict_taken), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
